// File: rtl/updown_ctrl.sv
// Push-button mode controller for the up/down counter: sync, debounce, run/pause/edit FSM, digit blink.
// Define AUTO_REVERSE_EN to make terminal count reverse direction in RUN instead of pausing.
module updown_ctrl #(
  parameter int unsigned DB_CYCLES    = 16,
  parameter int unsigned BLINK_CYCLES = 8,
  parameter int unsigned NUM_DIGITS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_dir,
  input  logic       btn_load,
  input  logic       btn_next,
  input  logic       term_cnt,
  output logic       cnt_en,
  output logic       cnt_ud,
  output logic       cnt_load,
  output logic [2:0] numsel,
  output logic [7:0] blink_mask,
  output logic [2:0] state
);

  localparam int unsigned NB   = 4;
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned BL_W = (BLINK_CYCLES > 1) ? $clog2(2 * BLINK_CYCLES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_EDIT  = 3'd3;
  localparam logic [2:0] S_LOAD  = 3'd4;

  // Button bit order: [3]=start, [2]=load, [1]=dir, [0]=next (also the priority order)
  logic [NB-1:0]   raw;
  logic [NB-1:0]   sync1;
  logic [NB-1:0]   sync2;
  logic [NB-1:0]   db;
  logic [NB-1:0]   db_d;
  logic [NB-1:0]   press;
  logic [DB_W-1:0] db_cnt [NB];
  logic            term_q;

  assign raw = {btn_start, btn_load, btn_dir, btn_next};

  // Synchronise, debounce and edge-detect all four buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_d   <= '0;
      press  <= '0;
      term_q <= 1'b0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      db_d   <= db;
      press  <= db & ~db_d;
      term_q <= term_cnt;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Only the highest-priority press in a cycle survives
  logic p_start, p_load, p_dir, p_next;
  assign p_start = press[3];
  assign p_load  = press[2] & ~press[3];
  assign p_dir   = press[1] & ~(|press[3:2]);
  assign p_next  = press[0] & ~(|press[3:1]);

  logic [2:0]      state_nx;
  logic            ud_nx;
  logic [2:0]      numsel_nx;
  logic [BL_W-1:0] blink_cnt;
  logic [BL_W-1:0] blink_nx;
  logic            en_nx;
  logic            load_nx;
  logic [7:0]      mask_nx;

  always_comb begin
    state_nx  = state;
    ud_nx     = cnt_ud;
    numsel_nx = numsel;
    case (state)
      S_IDLE, S_PAUSE: begin
        if (p_start)     state_nx = S_RUN;
        else if (p_load) state_nx = S_EDIT;
        else if (p_dir)  ud_nx    = ~cnt_ud;
      end
      S_RUN: begin
        if (p_start)    state_nx = S_PAUSE;
        else if (p_dir) ud_nx    = ~cnt_ud;
        else if (term_q && (press == '0)) begin
`ifdef AUTO_REVERSE_EN
          ud_nx = ~cnt_ud;
`else
          state_nx = S_PAUSE;
`endif
        end
      end
      S_EDIT: begin
        if (p_start)     state_nx = S_PAUSE;
        else if (p_load) state_nx = S_LOAD;
        else if (p_next) numsel_nx = (numsel == 3'(NUM_DIGITS - 1)) ? 3'd0 : numsel + 3'd1;
      end
      S_LOAD:  state_nx = S_PAUSE;
      default: state_nx = S_IDLE;
    endcase

    // Blink phase restarts (mask-on first) on every EDIT entry
    if ((state_nx == S_EDIT) && (state != S_EDIT))       blink_nx = '0;
    else if (blink_cnt == BL_W'(2 * BLINK_CYCLES - 1))   blink_nx = '0;
    else                                                 blink_nx = blink_cnt + BL_W'(1);

    en_nx   = (state_nx == S_RUN);
    load_nx = (state_nx == S_LOAD);
    mask_nx = ((state_nx == S_EDIT) && (blink_nx < BL_W'(BLINK_CYCLES))) ? (8'b1 << numsel_nx) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt_en     <= 1'b0;
      cnt_ud     <= 1'b1;
      cnt_load   <= 1'b0;
      numsel     <= 3'd0;
      blink_mask <= 8'h00;
      blink_cnt  <= '0;
    end else begin
      state      <= state_nx;
      cnt_en     <= en_nx;
      cnt_ud     <= ud_nx;
      cnt_load   <= load_nx;
      numsel     <= numsel_nx;
      blink_mask <= mask_nx;
      blink_cnt  <= blink_nx;
    end
  end

endmodule

// File: tb/tb_updown_ctrl.sv
// Directed bench for updown_ctrl with DB_CYCLES=4, BLINK_CYCLES=8, NUM_DIGITS=8.
module tb_updown_ctrl;

  localparam int DB = 4;
  localparam logic [3:0] B_START = 4'b1000;
  localparam logic [3:0] B_LOAD  = 4'b0100;
  localparam logic [3:0] B_DIR   = 4'b0010;
  localparam logic [3:0] B_NEXT  = 4'b0001;

  logic       clk, rst, term_cnt;
  logic [3:0] btn;
  logic       cnt_en, cnt_ud, cnt_load;
  logic [2:0] numsel, state;
  logic [7:0] blink_mask;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   entry = 0;
  logic exp_ud;

  updown_ctrl #(.DB_CYCLES(DB), .BLINK_CYCLES(8), .NUM_DIGITS(8)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn[3]), .btn_dir(btn[1]), .btn_load(btn[2]), .btn_next(btn[0]),
    .term_cnt(term_cnt),
    .cnt_en(cnt_en), .cnt_ud(cnt_ud), .cnt_load(cnt_load),
    .numsel(numsel), .blink_mask(blink_mask), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Raise buttons and stop one edge before the FSM reacts (raw seen at k, FSM updates at k+3+DB)
  task automatic push(input logic [3:0] b);
    btn = b;
    repeat (DB + 3) tick();
  endtask

  // Release and let debounced levels settle back to 0
  task automatic rel();
    btn = '0;
    repeat (DB + 4) tick();
  endtask

  task automatic blink_sweep(input logic [7:0] on_mask);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("blink", blink_mask, (((cyc - entry) % 16) < 8) ? on_mask : 8'h00);
    end
  endtask

  initial begin
    rst = 1'b0; btn = '0; term_cnt = 1'b0; exp_ud = 1'b1;
    repeat (3) tick();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_en", 8'(cnt_en), 8'd0);
    chk("rst_ud", 8'(cnt_ud), 8'd1);
    chk("rst_load", 8'(cnt_load), 8'd0);
    chk("rst_numsel", 8'(numsel), 8'd0);
    chk("rst_mask", blink_mask, 8'h00);
    rst = 1'b1;
    tick();

    // Glitch of 3 cycles is shorter than DB
    btn = B_START;
    repeat (3) tick();
    btn = '0;
    repeat (12) tick();
    chk("glitch_state", 8'(state), 8'd0);

    // IDLE -> EDIT, blink with numsel=0
    push(B_LOAD);
    tick();
    entry = cyc;
    chk("edit_state", 8'(state), 8'd3);
    chk("edit_mask0", blink_mask, 8'h01);
    rel();
    blink_sweep(8'h01);

    // Cursor advance x9 wraps to 1
    for (int n = 1; n <= 9; n++) begin
      push(B_NEXT);
      tick();
      chk("numsel", 8'(numsel), 8'(n % 8));
      rel();
    end
    blink_sweep(8'h02);

    // Commit: one-cycle LOAD then PAUSE
    push(B_LOAD);
    tick();
    chk("load_state", 8'(state), 8'd4);
    chk("load_strobe", 8'(cnt_load), 8'd1);
    chk("load_numsel", 8'(numsel), 8'd1);
    chk("load_mask", blink_mask, 8'h00);
    tick();
    chk("after_load_state", 8'(state), 8'd2);
    chk("after_load_strobe", 8'(cnt_load), 8'd0);
    chk("after_load_mask", blink_mask, 8'h00);
    rel();
    chk("pause_mask", blink_mask, 8'h00);

    // PAUSE -> RUN with exact latency
    push(B_START);
    chk("run_early_state", 8'(state), 8'd2);
    tick();
    chk("run_state", 8'(state), 8'd1);
    chk("run_en", 8'(cnt_en), 8'd1);
    chk("run_ud", 8'(cnt_ud), 8'd1);
    rel();

    // Terminal count in RUN
    term_cnt = 1'b1;
    tick();
    term_cnt = 1'b0;
    chk("term_wait_state", 8'(state), 8'd1);
    tick();
`ifdef AUTO_REVERSE_EN
    exp_ud = 1'b0;
    chk("term_state", 8'(state), 8'd1);
    chk("term_ud", 8'(cnt_ud), 8'(exp_ud));
    chk("term_en", 8'(cnt_en), 8'd1);
    push(B_START);
    tick();
    rel();
`else
    chk("term_state", 8'(state), 8'd2);
    chk("term_ud", 8'(cnt_ud), 8'(exp_ud));
    chk("term_en", 8'(cnt_en), 8'd0);
`endif

    // start + load together from PAUSE: start wins
    push(B_START | B_LOAD);
    tick();
    chk("prio_state", 8'(state), 8'd1);
    chk("prio_en", 8'(cnt_en), 8'd1);
    rel();
    chk("prio_no_edit", 8'(state), 8'd1);

    // dir + next together: dir wins, numsel untouched
    push(B_DIR | B_NEXT);
    tick();
    exp_ud = ~exp_ud;
    chk("dirnext_ud", 8'(cnt_ud), 8'(exp_ud));
    chk("dirnext_numsel", 8'(numsel), 8'd1);
    chk("dirnext_state", 8'(state), 8'd1);
    rel();

    // RUN -> PAUSE -> EDIT -> LOAD, then reset inside LOAD
    push(B_START);
    tick();
    chk("pause2_state", 8'(state), 8'd2);
    rel();
    push(B_LOAD);
    tick();
    chk("edit2_state", 8'(state), 8'd3);
    rel();
    push(B_LOAD);
    tick();
    chk("load2_strobe", 8'(cnt_load), 8'd1);
    rst = 1'b0;
    #1;
    chk("rst_load_strobe", 8'(cnt_load), 8'd0);
    chk("rst_load_state", 8'(state), 8'd0);
    chk("rst_load_numsel", 8'(numsel), 8'd0);
    chk("rst_load_ud", 8'(cnt_ud), 8'd1);
    btn = '0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (12) tick();
    chk("post_rst_state", 8'(state), 8'd0);
    chk("post_rst_en", 8'(cnt_en), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/updown_ctrl.md
# updown_ctrl

Mode controller that sequences the up/down counter datapath from four raw push-buttons. It synchronises and debounces the buttons, then runs a small state machine. The state machine drives the counter's enable, direction and load strobe, plus the digit-select cursor used when loading a value. It also produces a blink mask for the seven-segment driver so the digit being edited flashes. It sits between the board buttons and the counter, in the same clock domain as the counter.

## Interface
- DB_CYCLES, 16, consecutive stable cycles required before a synchronised button level is accepted.
- BLINK_CYCLES, 8, cycles per blink half-period (mask on for BLINK_CYCLES, off for BLINK_CYCLES).
- NUM_DIGITS, 8, number of editable digits; cursor wraps modulo this value (max 8).
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- btn_start  in  1  raw run/pause button, active-high.
- btn_dir  in  1  raw direction-toggle button.
- btn_load  in  1  raw edit/commit button.
- btn_next  in  1  raw cursor-advance button.
- term_cnt  in  1  counter terminal-count flag, sampled on clk.
- cnt_en  out  1  counter enable.
- cnt_ud  out  1  direction: 1 = up, 0 = down.
- cnt_load  out  1  one-cycle load strobe.
- numsel  out  3  digit cursor.
- blink_mask  out  8  one-hot digit blank mask for the display driver.
- state  out  3  current state encoding.

## Operation
- Each button has a 2-flop synchroniser followed by a debounce counter. The debounced level updates only after the synchronised level has differed from it for DB_CYCLES consecutive cycles. A debounced 0→1 edge produces an internal one-cycle press pulse. Releases produce no event.
- States: IDLE=0, RUN=1, PAUSE=2, EDIT=3, LOAD=4. Encodings 5–7 are illegal; the next state is IDLE.
- IDLE: cnt_en=0. start→RUN; load→EDIT; dir toggles cnt_ud.
- RUN: cnt_en=1. start→PAUSE; dir toggles cnt_ud and stays in RUN; load and next are ignored. term_cnt=1 is handled per Configuration.
- PAUSE: cnt_en=0. start→RUN; load→EDIT; dir toggles cnt_ud.
- EDIT: cnt_en=0. next advances numsel to (numsel+1) mod NUM_DIGITS; load→LOAD; start→PAUSE (abort, no load).
- LOAD: cnt_load=1 for exactly this one cycle, numsel is held; unconditionally →PAUSE on the next edge.
- Simultaneous presses in one cycle: priority is start > load > dir > next. Only the highest-priority press is acted on; the others are discarded, not queued.
- Presses arriving in LOAD are discarded.
- Blink: a free-running phase counter of period 2·BLINK_CYCLES, cleared on entry to EDIT with the mask-on phase first.
  - In EDIT: blink_mask = one-hot(numsel) during the on-phase and 0 during the off-phase.
  - In all other states: blink_mask = 0.
- numsel holds its value across state changes and is cleared only by reset.

## Timing
- Reset values: state=IDLE, cnt_en=0, cnt_ud=1, cnt_load=0, numsel=0, blink_mask=0. Synchroniser and debounce state are 0; blink counter is 0.
- A raw button rising at edge k, then held stable, produces its press pulse in cycle k+2+DB_CYCLES. The state and registered outputs update at edge k+3+DB_CYCLES.
- All outputs are registered. There is no combinational path from any input to any output.
- A button glitch shorter than DB_CYCLES cycles produces no press.
- term_cnt is acted on at the edge after it is sampled high in RUN. A press in the same cycle takes priority over term_cnt.
- Reset asserted mid-operation, including during LOAD, forces the reset values immediately; any pending cnt_load is dropped.

## Configuration
- AUTO_REVERSE_EN defined: in RUN, term_cnt=1 toggles cnt_ud and the block stays in RUN (ping-pong counting).
- AUTO_REVERSE_EN undefined: in RUN, term_cnt=1 moves to PAUSE (cnt_en=0) and cnt_ud is unchanged.

## Test plan
- Reset, then DB_CYCLES=4, press start held 10 cycles -> state=1 and cnt_en=1 at edge 7 after press; cnt_ud=1.
- Start pulse of 3 cycles -> no state change; state stays 0.
- From IDLE: load, then next ×9, then load (NUM_DIGITS=8) -> numsel=1, cnt_load high for exactly 1 cycle, then state=2. In EDIT, blink_mask toggles 8'h02/8'h00 every 8 cycles; it is 0 after leaving EDIT.
- In RUN, term_cnt=1 for 1 cycle -> with AUTO_REVERSE_EN: cnt_ud 1→0 and state stays 1; without it: state=2 and cnt_en=0.
- start and load debounced in the same cycle from PAUSE -> state=1 and no EDIT entry. Then dir+next together -> cnt_ud toggles and numsel is unchanged.
- Reset asserted in the LOAD cycle -> cnt_load=0, state=0 and numsel=0 immediately, without waiting for a clock edge.
